// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, imem req/ack handshake, prefetch FIFO feeding IF/ID.
// Optional macro FETCH_STATS_EN adds the stat_drops counter of redirect-discarded words.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h7E00_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        IFID_write,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
`ifdef FETCH_STATS_EN
    output logic [15:0] stat_drops,
`endif
    output logic [31:0] IF_instruction,
    output logic [31:0] IF_pcplus4,
    output logic        IF_valid
);

    // DEPTH is 2 or 4, so pointers wrap naturally at their width.
    localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_imem_addr;
    logic          r_imem_req;

    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc4   [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_next;
    logic          w_space;
    state_t        w_state_next;
    logic [31:0]   w_pc_next;
    logic [31:0]   w_addr_next;

    assign w_pop        = IFID_write && (r_count != '0) && !redirect;
    assign w_push       = (r_state == StReq) && imem_ack && !redirect;
    assign w_count_next = redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_space      = (w_count_next < CW'(DEPTH));

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_fetch_pc;
        unique case (r_state)
            StIdle: begin
                if (redirect || w_space) w_state_next = StReq;
            end
            StReq: begin
                if (redirect) begin
                    w_state_next = imem_ack ? StReq : StDrop;
                end else if (imem_ack) begin
                    w_pc_next    = r_fetch_pc + 32'd4;
                    w_state_next = w_space ? StReq : StIdle;
                end
            end
            StDrop: begin
                if (imem_ack) w_state_next = StReq;
            end
            default: w_state_next = StIdle;
        endcase
        if (redirect) w_pc_next = redirect_target;
        // While draining a stale request the memory must keep seeing the old address.
        w_addr_next = (w_state_next == StDrop) ? r_imem_addr : w_pc_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_imem_req  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_pc_next;
            r_imem_addr <= w_addr_next;
            r_imem_req  <= (w_state_next != StIdle);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // Storage needs no reset: contents are only visible while r_count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= imem_rdata;
            r_pc4[r_wr_ptr]   <= r_imem_addr + 32'd4;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] r_stat_drops;
    logic        w_drop;

    assign w_drop = imem_ack && (((r_state == StReq) && redirect) || (r_state == StDrop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_drops <= 16'h0000;
        end else if (w_drop && (r_stat_drops != 16'hFFFF)) begin
            r_stat_drops <= r_stat_drops + 16'd1;
        end
    end

    assign stat_drops = r_stat_drops;
`endif

    assign imem_req       = r_imem_req;
    assign imem_addr      = r_imem_addr;
    assign IF_valid       = (r_count != '0);
    assign IF_instruction = IF_valid ? r_instr[r_rd_ptr] : NOP_INSTR;
    assign IF_pcplus4     = IF_valid ? r_pc4[r_rd_ptr] : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default DEPTH=2, RESET_PC=0).
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h7E00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        IFID_write;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] IF_instruction;
    logic [31:0] IF_pcplus4;
    logic        IF_valid;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_drops;
`endif

    logic zw;
    logic man_ack;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acks;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: zero-wait (ack follows req) or manually released ack.
    assign imem_ack   = zw ? imem_req : (man_ack && imem_req);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or posedge reset) begin
        if (reset) n_acks <= 0;
        else if (imem_req && imem_ack) n_acks <= n_acks + 1;
    end

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .IFID_write     (IFID_write),
        .redirect       (redirect),
        .redirect_target(redirect_target),
`ifdef FETCH_STATS_EN
        .stat_drops     (stat_drops),
`endif
        .IF_instruction (IF_instruction),
        .IF_pcplus4     (IF_pcplus4),
        .IF_valid       (IF_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic restart;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; zw = 1'b1; man_ack = 1'b0;
        IFID_write = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
        tick();
        check_eq("rst_req",   {31'h0, imem_req}, 32'h0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_instr", IF_instruction, NOP);
        check_eq("rst_pc4",   IF_pcplus4, 32'h0);
        check_eq("rst_valid", {31'h0, IF_valid}, 32'h0);
        tick();
        reset = 1'b0;

        // Zero-wait streaming
        tick();
        check_eq("s1_req",   {31'h0, imem_req}, 32'h1);
        check_eq("s1_addr",  imem_addr, 32'h0);
        check_eq("s1_valid", {31'h0, IF_valid}, 32'h0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_eq("s_addr",  imem_addr, 32'(4 * (k - 1)));
            check_eq("s_pc4",   IF_pcplus4, 32'(4 * (k - 1)));
            check_eq("s_instr", IF_instruction, mem_word(32'(4 * (k - 2))));
            check_eq("s_valid", {31'h0, IF_valid}, 32'h1);
        end

        // Stall with full FIFO
        IFID_write = 1'b0;
        restart();
        tick();
        check_eq("st1_addr", imem_addr, 32'h0);
        tick();
        check_eq("st2_pc4",  IF_pcplus4, 32'h4);
        check_eq("st2_addr", imem_addr, 32'h4);
        tick();
        check_eq("st3_req",  {31'h0, imem_req}, 32'h0);
        tick();
        check_eq("st4_req",  {31'h0, imem_req}, 32'h0);
        tick();
        check_eq("st5_req",  {31'h0, imem_req}, 32'h0);
        check_eq("st5_acks", n_acks, 32'd2);
        check_eq("st5_pc4",  IF_pcplus4, 32'h4);
        check_eq("st5_addr", imem_addr, 32'h8);
        IFID_write = 1'b1;
        tick();
        check_eq("st6_pc4",   IF_pcplus4, 32'h8);
        check_eq("st6_instr", IF_instruction, mem_word(32'h4));
        check_eq("st6_req",   {31'h0, imem_req}, 32'h1);
        tick();
        check_eq("st7_pc4",   IF_pcplus4, 32'hC);
        check_eq("st7_instr", IF_instruction, mem_word(32'h8));

        // Redirect during a delayed ack
        zw = 1'b0; man_ack = 1'b0;
        restart();
        tick();
        check_eq("d1_addr", imem_addr, 32'h0);
        redirect = 1'b1; redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        check_eq("d2_req",   {31'h0, imem_req}, 32'h1);
        check_eq("d2_addr",  imem_addr, 32'h0);
        check_eq("d2_valid", {31'h0, IF_valid}, 32'h0);
        tick();
        check_eq("d3_addr", imem_addr, 32'h0);
        man_ack = 1'b1;
        tick();
        check_eq("d4_addr",  imem_addr, 32'h100);
        check_eq("d4_valid", {31'h0, IF_valid}, 32'h0);
`ifdef FETCH_STATS_EN
        check_eq("d4_drops", {16'h0, stat_drops}, 32'd1);
`endif
        tick();
        check_eq("d5_valid", {31'h0, IF_valid}, 32'h1);
        check_eq("d5_pc4",   IF_pcplus4, 32'h104);
        check_eq("d5_instr", IF_instruction, mem_word(32'h100));
        check_eq("d5_addr",  imem_addr, 32'h104);

        // Redirect with buffered entry and simultaneous ack
        IFID_write = 1'b0; redirect = 1'b1; redirect_target = 32'h200;
        tick();
        check_eq("r_instr", IF_instruction, NOP);
        check_eq("r_valid", {31'h0, IF_valid}, 32'h0);
        check_eq("r_pc4",   IF_pcplus4, 32'h0);
        check_eq("r_addr",  imem_addr, 32'h200);
`ifdef FETCH_STATS_EN
        check_eq("r_drops", {16'h0, stat_drops}, 32'd2);
`endif

        // PC wrap
        zw = 1'b1; IFID_write = 1'b1; redirect_target = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        check_eq("w1_addr",  imem_addr, 32'hFFFF_FFF8);
        check_eq("w1_valid", {31'h0, IF_valid}, 32'h0);
        tick();
        check_eq("w2_pc4",  IF_pcplus4, 32'hFFFF_FFFC);
        check_eq("w2_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("w3_pc4",   IF_pcplus4, 32'h0);
        check_eq("w3_valid", {31'h0, IF_valid}, 32'h1);
        check_eq("w3_instr", IF_instruction, mem_word(32'hFFFF_FFFC));
        check_eq("w3_addr",  imem_addr, 32'h0);
        tick();
        check_eq("w4_pc4",  IF_pcplus4, 32'h4);
        check_eq("w4_addr", imem_addr, 32'h4);

        // Asynchronous reset with request pending
        reset = 1'b1;
        #1;
        check_eq("ar_req",   {31'h0, imem_req}, 32'h0);
        check_eq("ar_addr",  imem_addr, 32'h0);
        check_eq("ar_valid", {31'h0, IF_valid}, 32'h0);
        check_eq("ar_instr", IF_instruction, NOP);
        check_eq("ar_pc4",   IF_pcplus4, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
